// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Single outstanding request; one rvalid strobe per request.
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// IF stage: owns the fetch PC, issues single-outstanding imem requests and
// drives the IF/ID register, handling stall, redirect and stale responses.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    instruction_fetch_if.master        imem,
    input  logic [1:0]                 next_pc_sel,
    input  logic [31:0]                jump_addr,
    input  logic [31:0]                trap_addr,
    input  logic                       stall,
    output logic [31:0]                inst_o,
    output logic [31:0]                pc_o,
    output logic                       inst_valid
);

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        JUMP     = 2'b01,
        TRAP     = 2'b10
    } next_pc_type_e;

    typedef enum logic [1:0] {
        BOOT     = 2'b00,
        WAIT_RSP = 2'b01,
        HOLD     = 2'b10,
        DISCARD  = 2'b11
    } fetch_state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_state_e state_q;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  buf_inst_q;
    logic [31:0]  inst_q;
    logic [31:0]  pc_q;
    logic         valid_q;

    logic         redirect;
    logic [31:0]  target_raw;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;
    logic         req;
    logic [31:0]  req_addr;

    assign redirect   = (next_pc_sel != PC_PLUS4);
    assign target_raw = next_pc_sel[1] ? trap_addr : jump_addr;
    assign target     = {target_raw[31:2], 2'b00};
    assign pc_plus4   = fetch_pc_q + 32'd4;

    // Request is combinational so a response can be followed by the next
    // request in the same cycle (1 instruction/cycle with 1-cycle memory).
    always_comb begin
        req      = 1'b0;
        req_addr = fetch_pc_q;
        if (!rst) begin
            case (state_q)
                BOOT: begin
                    req      = 1'b1;
                    req_addr = redirect ? target : fetch_pc_q;
                end
                WAIT_RSP: begin
                    if (imem.imem_rvalid) begin
                        if (redirect) begin
                            req      = 1'b1;
                            req_addr = target;
                        end else if (!stall) begin
                            req      = 1'b1;
                            req_addr = pc_plus4;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        req      = 1'b1;
                        req_addr = target;
                    end else if (!stall) begin
                        req      = 1'b1;
                        req_addr = pc_plus4;
                    end
                end
                DISCARD: begin
                    if (imem.imem_rvalid) begin
                        req      = 1'b1;
                        req_addr = redirect ? target : fetch_pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = req_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            buf_inst_q <= '0;
            inst_q     <= NOP;
            pc_q       <= '0;
            valid_q    <= 1'b0;
        end else begin
            // A redirect always bubbles IF/ID; pc_o is deliberately kept.
            if (redirect) begin
                inst_q  <= NOP;
                valid_q <= 1'b0;
            end
            case (state_q)
                BOOT: begin
                    if (redirect) begin
                        fetch_pc_q <= target;
                    end
                    state_q <= WAIT_RSP;
                end
                WAIT_RSP: begin
                    if (redirect) begin
                        fetch_pc_q <= target;
                        if (!imem.imem_rvalid) begin
                            state_q <= DISCARD;
                        end
                    end else if (imem.imem_rvalid) begin
                        if (!stall) begin
                            inst_q     <= imem.imem_rdata;
                            pc_q       <= fetch_pc_q;
                            valid_q    <= 1'b1;
                            fetch_pc_q <= pc_plus4;
                        end else begin
                            buf_inst_q <= imem.imem_rdata;
                            state_q    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        fetch_pc_q <= target;
                        state_q    <= WAIT_RSP;
                    end else if (!stall) begin
                        inst_q     <= buf_inst_q;
                        pc_q       <= fetch_pc_q;
                        valid_q    <= 1'b1;
                        fetch_pc_q <= pc_plus4;
                        state_q    <= WAIT_RSP;
                    end
                end
                DISCARD: begin
                    // Waiting out a stale response; its data is never used.
                    if (redirect) begin
                        fetch_pc_q <= target;
                    end
                    if (imem.imem_rvalid) begin
                        state_q <= WAIT_RSP;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign inst_o     = inst_q;
    assign pc_o       = pc_q;
    assign inst_valid = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a variable-latency memory model
// and a scoreboard of expected IF/ID loads.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  next_pc_sel;
    logic [31:0] jump_addr;
    logic [31:0] trap_addr;
    logic        stall;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_valid;

    instruction_fetch_if imem();

    instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem),
        .next_pc_sel (next_pc_sel),
        .jump_addr   (jump_addr),
        .trap_addr   (trap_addr),
        .stall       (stall),
        .inst_o      (inst_o),
        .pc_o        (pc_o),
        .inst_valid  (inst_valid)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          mem_lat  = 1;
    logic [31:0] exp_q[$];

    logic        mem_req_seen;
    logic [31:0] mem_addr_seen;
    logic        mem_pend;
    int          mem_rem;
    logic [31:0] mem_pend_addr;
    logic        sb_prev_valid;
    logic [31:0] sb_prev_pc;
    logic [31:0] sb_exp;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
        check({tag, "_req"}, {31'b0, imem.imem_req}, {31'b0, r});
        if (r) check({tag, "_addr"}, imem.imem_addr, a);
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] p);
        check({tag, "_valid"}, {31'b0, inst_valid}, {31'b0, v});
        check({tag, "_pc"}, pc_o, p);
        check({tag, "_inst"}, inst_o, v ? word_of(p) : NOP);
    endtask

    // Memory: request seen in cycle N answers in cycle N+mem_lat.
    initial begin
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '0;
        mem_pend         = 1'b0;
        mem_rem          = 0;
        mem_pend_addr    = '0;
        forever begin
            @(negedge clk);
            mem_req_seen  = imem.imem_req;
            mem_addr_seen = imem.imem_addr;
            @(posedge clk);
            #1;
            imem.imem_rvalid = 1'b0;
            if (rst) begin
                mem_pend = 1'b0;
            end else begin
                if (mem_req_seen) begin
                    check("one_outstanding", {31'b0, mem_pend}, 32'd0);
                    mem_pend      = 1'b1;
                    mem_rem       = mem_lat;
                    mem_pend_addr = mem_addr_seen;
                end
                if (mem_pend) begin
                    mem_rem--;
                    if (mem_rem == 0) begin
                        imem.imem_rvalid = 1'b1;
                        imem.imem_rdata  = word_of(mem_pend_addr);
                        mem_pend         = 1'b0;
                    end
                end
            end
        end
    end

    // Scoreboard: every new valid IF/ID content pops one expected PC.
    initial begin
        sb_prev_valid = 1'b0;
        sb_prev_pc    = '0;
        forever begin
            @(negedge clk);
            if (!rst && inst_valid && (!sb_prev_valid || pc_o != sb_prev_pc) && exp_q.size() > 0) begin
                sb_exp = exp_q.pop_front();
                check("sb_pc", pc_o, sb_exp);
                check("sb_inst", inst_o, word_of(sb_exp));
            end
            sb_prev_valid = inst_valid;
            sb_prev_pc    = pc_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        next_pc_sel = 2'b00;
        jump_addr   = '0;
        trap_addr   = '0;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        exp_q.push_back(32'h10C);

        // Reset state
        settle();
        chk_ifid("reset", 1'b0, 32'h0);
        chk_req("reset", 1'b0, 32'h0);
        check("reset_req_low", {31'b0, imem.imem_req}, 32'd0);

        // Reset release and 1-cycle stream
        step(); rst = 1'b0;
        settle(); $display("step boot: req@%h", imem.imem_addr);
        chk_req("boot", 1'b1, 32'h100);
        step(); settle(); chk_req("c1", 1'b1, 32'h104);
        step(); settle(); chk_ifid("c2", 1'b1, 32'h100);
        $display("step stream: pc_o=%h", pc_o);
        step(); stall = 1'b1;
        settle(); chk_ifid("stall0", 1'b1, 32'h104); chk_req("stall0", 1'b0, 32'h0);
        step(); settle(); chk_ifid("stall1", 1'b1, 32'h104); chk_req("stall1", 1'b0, 32'h0);
        step(); settle(); chk_ifid("stall2", 1'b1, 32'h104); chk_req("stall2", 1'b0, 32'h0);
        step(); stall = 1'b0;
        settle(); chk_req("release", 1'b1, 32'h10C); chk_ifid("release", 1'b1, 32'h104);
        step(); settle(); chk_ifid("post_release", 1'b1, 32'h108);
        $display("step stall release: pc_o=%h inst_o=%h", pc_o, inst_o);
        step(); settle();

        // Jump while a 3-cycle fetch is in flight
        step(); next_pc_sel = 2'b01; jump_addr = 32'h200; mem_lat = 3;
        settle(); chk_req("j0", 1'b1, 32'h200);
        #1 exp_q.push_back(32'h2000);
        step(); next_pc_sel = 2'b01; jump_addr = 32'h0000_2002;
        settle(); chk_req("j1", 1'b0, 32'h0); check("j1_valid", {31'b0, inst_valid}, 32'd0);
        step(); next_pc_sel = 2'b00;
        settle(); chk_req("j2", 1'b0, 32'h0); check("j2_valid", {31'b0, inst_valid}, 32'd0);
        step(); settle(); chk_req("j3_stale", 1'b1, 32'h2000); check("j3_valid", {31'b0, inst_valid}, 32'd0);
        step(); settle(); check("j4_valid", {31'b0, inst_valid}, 32'd0);
        step(); settle(); check("j5_valid", {31'b0, inst_valid}, 32'd0);
        step(); settle(); check("j6_valid", {31'b0, inst_valid}, 32'd0); chk_req("j6", 1'b1, 32'h2004);
        step(); settle(); chk_ifid("j7", 1'b1, 32'h2000);
        $display("step jump: pc_o=%h valid=%0d", pc_o, inst_valid);

        // Trap while holding a buffered word under stall
        step(); settle();
        step(); stall = 1'b1;
        settle(); chk_req("hold_entry", 1'b0, 32'h0);
        step(); next_pc_sel = 2'b11; trap_addr = 32'h80; jump_addr = 32'h4444;
        settle(); chk_req("trap", 1'b1, 32'h80);
        #1 exp_q.push_back(32'h80);
        step(); next_pc_sel = 2'b00; stall = 1'b0;
        settle(); chk_ifid("trap_bubble", 1'b0, 32'h2000);
        $display("step trap: pc_o=%h inst_o=%h valid=%0d", pc_o, inst_o, inst_valid);
        step(); settle(); chk_req("t2", 1'b0, 32'h0);
        step(); settle(); chk_req("t3", 1'b1, 32'h84);

        // Wrap-around
        step(); next_pc_sel = 2'b01; jump_addr = 32'hFFFF_FFFC; mem_lat = 1;
        settle(); chk_ifid("t4", 1'b1, 32'h80); chk_req("w0", 1'b0, 32'h0);
        #1 begin exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); end
        step(); next_pc_sel = 2'b00;
        settle(); chk_req("w1", 1'b0, 32'h0); check("w1_valid", {31'b0, inst_valid}, 32'd0);
        step(); settle(); chk_req("w2", 1'b1, 32'hFFFF_FFFC);
        step(); settle(); chk_req("wrap", 1'b1, 32'h0);
        $display("step wrap: req@%h", imem.imem_addr);
        step(); settle(); chk_ifid("w4", 1'b1, 32'hFFFF_FFFC);
        step(); settle(); chk_ifid("w5", 1'b1, 32'h0);
        step(); settle(); chk_ifid("w6", 1'b1, 32'h4);

        // Async reset while in DISCARD
        step(); next_pc_sel = 2'b01; jump_addr = 32'h300; mem_lat = 3;
        settle(); chk_req("k0", 1'b1, 32'h300);
        step(); next_pc_sel = 2'b01; jump_addr = 32'h400;
        settle(); chk_req("k1", 1'b0, 32'h0);
        step(); next_pc_sel = 2'b00;
        #1; check("pre_rst_pc_held", pc_o, 32'h8);
        rst = 1'b1;
        exp_q.push_back(32'h100);
        #1; chk_ifid("async_rst", 1'b0, 32'h0); chk_req("async_rst", 1'b0, 32'h0);
        $display("step async reset: pc_o=%h inst_o=%h valid=%0d", pc_o, inst_o, inst_valid);
        @(posedge clk); #2; rst = 1'b0;
        settle(); chk_req("r0", 1'b1, 32'h100); chk_ifid("r0", 1'b0, 32'h0);
        step(); settle(); chk_req("r1", 1'b0, 32'h0); chk_ifid("r1", 1'b0, 32'h0);
        step(); settle(); chk_req("r2", 1'b0, 32'h0); chk_ifid("r2", 1'b0, 32'h0);
        step(); settle(); chk_req("r3", 1'b1, 32'h104); chk_ifid("r3", 1'b0, 32'h0);
        step(); settle(); chk_ifid("r4", 1'b1, 32'h100);
        $display("step post reset: pc_o=%h valid=%0d", pc_o, inst_valid);
        step(); settle();
        check("sb_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch (IF) stage of the riscv-small pipeline. It owns the fetch PC and selects the next PC from `nextPCType_e`. It runs a single-outstanding-request handshake with instruction memory and drives the IF/ID pipeline register (`instruction_u` plus PC) consumed by decode. It handles stall from the hazard unit and redirect (jump/trap) from execute, including discarding in-flight stale responses.

## Interface
- `RESET_PC`, default `32'h0000_0000`: fetch address after reset.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `next_pc_sel`  in  2  `nextPCType_e`. `PC_PLUS4` means no redirect, `JUMP` (2'b01) means redirect to `jump_addr`, `TRAP` (2'b1?) means redirect to `trap_addr`.
- `jump_addr`  in  32  branch/jump target from execute.
- `trap_addr`  in  32  trap vector.
- `stall`  in  1  hold IF/ID register and stop issuing fetches.
- `imem_req`  out  1  request strobe, one cycle per request (combinational).
- `imem_addr`  out  32  request address, valid while `imem_req`=1 (combinational).
- `imem_rvalid`  in  1  response strobe.
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`.
- `inst_o`  out  32  `instruction_u` in IF/ID.
- `pc_o`  out  32  address of `inst_o`.
- `inst_valid`  out  1  IF/ID holds a real instruction.

## Operation
- Memory contract: at most one outstanding request. Exactly one `imem_rvalid` per request, at least 1 cycle after it. `imem_rvalid` is never asserted with no request outstanding.
- Registers:
  - `fetch_pc`: address of the outstanding or next request.
  - `state`: BOOT, WAIT_RSP, HOLD, DISCARD.
  - `buf_inst`: skid buffer.
  - IF/ID: `inst_o`, `pc_o`, `inst_valid`.
- Redirect: `redirect = (next_pc_sel != PC_PLUS4)`. Target is `trap_addr` if `next_pc_sel[1]`, else `jump_addr`. Target bits [1:0] are forced to 0.
- Redirect always beats stall. Redirect always bubbles IF/ID: `inst_valid`←0, `inst_o`←`32'h0000_0013` (NOP), `pc_o` held.
- Load IF/ID means: `inst_o`←word, `pc_o`←`fetch_pc`, `inst_valid`←1. Without a load or redirect, IF/ID holds.
- PC increment is `fetch_pc+4`, modulo 2^32 (`32'hFFFF_FFFC` → `32'h0`).
- Transitions:
  - BOOT, no redirect: req @`fetch_pc`, go to WAIT_RSP.
  - BOOT, redirect: req @target, `fetch_pc`←target, go to WAIT_RSP.
  - WAIT_RSP, rvalid and redirect: drop the word, req @target, `fetch_pc`←target, stay.
  - WAIT_RSP, no rvalid, redirect: no req, `fetch_pc`←target, go to DISCARD.
  - WAIT_RSP, rvalid, no stall: load IF/ID from `imem_rdata`, req @`fetch_pc+4`, `fetch_pc`←`fetch_pc+4`, stay.
  - WAIT_RSP, rvalid, stall: `buf_inst`←`imem_rdata`, no req, go to HOLD.
  - HOLD, redirect: drop buffer, req @target, `fetch_pc`←target, go to WAIT_RSP.
  - HOLD, no stall: load IF/ID from `buf_inst`, req @`fetch_pc+4`, `fetch_pc`+=4, go to WAIT_RSP.
  - HOLD, stall: hold.
  - DISCARD, redirect: `fetch_pc`←new target. If rvalid in the same cycle, drop the word, req @new target, go to WAIT_RSP.
  - DISCARD, rvalid, no redirect: drop the word, req @`fetch_pc`, go to WAIT_RSP.
  - WAIT_RSP, no rvalid, no redirect: idle, no req.
- A stale (pre-redirect) response never reaches IF/ID.

## Timing
- Reset values (immediate, asynchronous):
  - `state`=BOOT, `fetch_pc`=`RESET_PC`, `buf_inst`=0.
  - `inst_o`=`32'h0000_0013`, `pc_o`=0, `inst_valid`=0.
  - `imem_req`=0 while `rst`=1.
- First cycle after reset release: `imem_req`=1, `imem_addr`=`RESET_PC`.
- `imem_req`/`imem_addr` are combinational from state, `imem_rvalid`, `stall` and `next_pc_sel`. No other combinational path exists.
- With 1-cycle memory, the IF/ID word is visible the cycle after `imem_rvalid`. Throughput is 1 instruction/cycle with back-to-back req/rvalid.
- Memory latency L gives 1 instruction per L cycles.
- Redirect penalty: the target instruction appears in IF/ID L+1 cycles after the redirect cycle. Add the remaining stale latency when in DISCARD.
- Stall release from HOLD: IF/ID updates at the release edge, and the next request is issued in the release cycle.

## Test plan
- Reset and stream: `RESET_PC`=`0x100`, 1-cycle memory. Required: req@`0x100` the first cycle after reset; `pc_o`=`0x100`,`0x104`,`0x108` on consecutive cycles; `inst_valid` held at 1.
- Stall: `stall`=1 for 3 cycles while the `0x108` response arrives. Required: IF/ID holds `0x104`, no `imem_req`. At release: `pc_o`=`0x108` with the buffered word, and req@`0x10C` in the release cycle.
- Jump during in-flight fetch: 3-cycle memory, JUMP to `0x0000_2002` one cycle after req@`0x200`. Required: response for `0x200` dropped, req@`0x2000`, `inst_valid`=0 until `pc_o`=`0x2000`.
- Trap plus stall: `next_pc_sel`=2'b11, `trap_addr`=`0x80`, `stall`=1 in HOLD. Required: buffer dropped, req@`0x80`, IF/ID bubbled to NOP/0.
- Wrap-around: jump to `0xFFFF_FFFC`, 1-cycle memory. Required: next req@`0x0000_0000`.
- Async reset in DISCARD: `rst` asserted mid-cycle. Required: `inst_valid`=0 and `inst_o`=NOP before the next edge; after release, req@`RESET_PC`, and the late stale rvalid is not generated by the model.
